serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial add/subtract engine: accepts two WIDTH-bit operands on a valid/ready
//  handshake and drives one 1-bit full-adder cell LSB-first over WIDTH cycles.
//  A carry flip-flop links the bits. Result and flags are returned on a
//  valid/ready output handshake.
//  Sits between the ALU-op decoder and the writeback mux as an area-minimal adder path.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=2)
//  CNT_W   $clog2(WIDTH)   bit-counter width (derived, not overridden)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands + op_sub valid
//  in_ready   out  1      engine can accept (IDLE only)
//  op_sub     in   1      0: a+b, 1: a-b (two's complement: b inverted, carry-in=1)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum/difference
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
//  zero       out  1      result == 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0;
//    cout=overflow=0; zero=1; carry FF, counter and shift regs cleared.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid&&in_ready edge: a_sh<=a, b_sh<=op_sub?~b:b,
//      carry<=op_sub, cnt<=0 -> RUN.
//    RUN: in_ready=0. Each edge: the full-adder cell computes s,co from
//      (a_sh[0], b_sh[0], carry). result shifts right with s entering at MSB.
//      a_sh and b_sh shift right, carry<=co, cnt++.
//      When cnt==WIDTH-1: latch c_msb_in<=carry (pre-update) for overflow,
//      then -> DONE.
//    DONE: out_valid=1. result/cout/overflow/zero stable.
//      On out_valid&&out_ready edge -> IDLE.
//  - Latency: exactly WIDTH edges from the accept edge to out_valid=1.
//    Throughput is one op per WIDTH+2 cycles minimum with out_ready tied high.
//  - in_ready is combinational from state only; no dependence on in_valid (no loops).
//  - Backpressure: out_ready low holds DONE indefinitely with outputs frozen.
//    in_valid is ignored while not IDLE (operands not sampled).
//  - cout=carry after last bit; zero computed from final result register.
//  - in_valid changing mid-RUN: no effect. rst_n low mid-RUN: operation aborted,
//    no out_valid pulse after release.
//  - Counter wraps never: cleared on accept. No state beyond DONE; illegal state
//    encodings decode to IDLE.
// STRUCTURE
//  - Shared package serial_alu_pkg: state localparams ST_IDLE=2'd0, ST_RUN=2'd1,
//    ST_DONE=2'd2; OP_ADD=1'b0, OP_SUB=1'b1.
//  - One sub-module: Add1b (existing 1-bit full-adder cell, ports a,b,ci,s,co),
//    instantiated once. All sequencing, shift regs, carry FF in this module.
// TESTING (WIDTH=8)
//  1. add 8'h7F+8'h01 -> result=8'h80, cout=0, overflow=1, zero=0; out_valid
//     exactly 8 edges after accept.
//  2. add 8'hFF+8'h01 -> result=8'h00, cout=1, overflow=0, zero=1.
//  3. sub 8'h05-8'h07 -> result=8'hFE, cout=0 (borrow), overflow=0;
//     sub 8'h80-8'h01 -> 8'h7F, cout=1, overflow=1.
//  4. out_ready low 5 cycles in DONE -> out_valid and result held. in_valid
//     pulsed meanwhile not accepted (in_ready=0). Release -> IDLE, in_ready=1 next cycle.
//  5. rst_n low at RUN cnt=3 -> all outputs at reset values immediately.
//     No out_valid after release. Next op 8'h10+8'h20 -> 8'h30.
//  6. Back-to-back: in_valid and out_ready tied high, 100 random ops ->
//     results match a+b / a-b reference model, one accept per WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared state and opcode encodings for the bit-serial ALU path
package serial_alu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_add1b.sv
// rtl/serial_add_ctrl_add1b.sv - single-bit full-adder cell driven by the serial engine
module Add1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract engine, LSB-first through one full-adder cell
module serial_add_ctrl
    import serial_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               c_msb_in_q, c_msb_in_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_s;
    logic               fa_co;
    logic               accept;
    logic               last_bit;

    Add1b u_add1b (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused encodings fall into the default arm and behave as IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = accept ? ST_RUN : ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_ready = 1'b0;
            end
            ST_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 rides in on the initial carry.
    always_comb begin
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_d      = res_q;
        carry_d    = carry_q;
        c_msb_in_d = c_msb_in_q;
        cnt_d      = cnt_q;
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = (op_sub == OP_SUB) ? ~b : b;
            carry_d = op_sub;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
                c_msb_in_d = carry_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            c_msb_in_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            c_msb_in_q <= c_msb_in_d;
            cnt_q      <= cnt_d;
        end
    end

    assign result   = res_q;
    assign cout     = carry_q;
    assign overflow = c_msb_in_q ^ carry_q;
    assign zero     = ~|res_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int tests_run;
    int tests_failed;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, overflow, zero, result} from plain integer arithmetic.
    function automatic logic [W+2:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        int unsigned sum;
        logic [W-1:0] r;
        logic c, v;
        if (sub) sum = int'(x) + int'((~y) & 8'hFF) + 1;
        else     sum = int'(x) + int'(y);
        r = sum[W-1:0];
        c = sum[W];
        if (sub) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else     v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {c, v, (r == 0), r};
    endfunction

    function automatic logic [W+2:0] dut_flags();
        return {cout, overflow, zero, result};
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub, output int lat);
        @(negedge clk);
        a = x; b = y; op_sub = sub; in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", 32'(out_valid), 32'd0);
        check("in_ready_after_consume", 32'(in_ready), 32'd1);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        int lat;
        start_op(x, y, sub, lat);
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_flags"}, 32'(dut_flags()), 32'(ref_op(x, y, sub)));
        consume();
    endtask

    initial begin
        logic [W-1:0] held_res;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic         qs[$];
        int           lat;
        int           cyc;
        int           last_acc;
        int           done_ops;
        int           saw_valid;
        logic         acc_now;
        logic [W+2:0] exp_v;

        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        op_sub = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_flags", 32'(dut_flags()), {21'd0, 1'b0, 1'b0, 1'b1, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer cases with explicit expectations.
        start_op(8'h7F, 8'h01, 1'b0, lat);
        check("add_7f_01_latency", 32'(lat), 32'd8);
        check("add_7f_01_flags", 32'(dut_flags()), {21'd0, 1'b0, 1'b1, 1'b0, 8'h80});
        consume();
        start_op(8'hFF, 8'h01, 1'b0, lat);
        check("add_ff_01_flags", 32'(dut_flags()), {21'd0, 1'b1, 1'b0, 1'b1, 8'h00});
        consume();
        start_op(8'h05, 8'h07, 1'b1, lat);
        check("sub_05_07_flags", 32'(dut_flags()), {21'd0, 1'b0, 1'b0, 1'b0, 8'hFE});
        consume();
        start_op(8'h80, 8'h01, 1'b1, lat);
        check("sub_80_01_flags", 32'(dut_flags()), {21'd0, 1'b1, 1'b1, 1'b0, 8'h7F});
        consume();
        directed("sub_equal", 8'h5A, 8'h5A, 1'b1);

        // Backpressure: DONE must hold with outputs frozen and inputs refused.
        start_op(8'h3C, 8'h42, 1'b0, lat);
        held_res = result;
        check("bp_initial_result", 32'(held_res), 32'h7E);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = 8'hAA; b = 8'h11; op_sub = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            check("bp_result_held", 32'(result), 32'(held_res));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        check("bp_result_after_release", 32'(result), 32'(held_res));

        // Asynchronous reset mid-RUN, after three bit-steps.
        @(negedge clk);
        a = 8'hC3; b = 8'h3C; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_still_running", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_flags", 32'(dut_flags()), {21'd0, 1'b0, 1'b0, 1'b1, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        saw_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid++;
        end
        out_ready = 1'b0;
        check("abort_no_out_valid", 32'(saw_valid), 32'd0);
        directed("post_abort_10_20", 8'h10, 8'h20, 1'b0);
        check("post_abort_result", 32'(result), 32'h30);

        // Back-to-back random stream with both handshakes held high.
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'($urandom); b = 8'($urandom); op_sub = 1'($urandom);
        cyc = 0;
        last_acc = -1;
        done_ops = 0;
        while (done_ops < 100 && cyc < 2000) begin
            @(negedge clk);
            if (out_valid) begin
                if (qa.size() == 0) begin
                    check("stream_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_v = ref_op(qa.pop_front(), qb.pop_front(), qs.pop_front());
                    check("stream_flags", 32'(dut_flags()), 32'(exp_v));
                end
                done_ops++;
            end
            acc_now = in_ready;
            if (acc_now) begin
                qa.push_back(a); qb.push_back(b); qs.push_back(op_sub);
                if (last_acc >= 0) check("stream_accept_spacing", 32'(cyc - last_acc), 32'(W + 2));
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                a = 8'($urandom); b = 8'($urandom); op_sub = 1'($urandom);
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_completed_ops", 32'(done_ops), 32'd100);
        repeat (W + 4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
